// File: rtl/axi_lite_master_arbiter.sv
// axi_lite_master_arbiter: round-robin sharing of one AXI4-Lite master port between NUM_REQ requesters,
// one transaction at a time, with a watchdog that turns unanswered address phases into DECERR.
module axi_lite_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                             CLK,
    input  logic                             RESETN,
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    input  logic [NUM_REQ-1:0]               REQ_WRITE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  REQ_WSTRB,
    output logic [NUM_REQ-1:0]               REQ_READY,
    output logic [NUM_REQ-1:0]               RSP_VALID,
    output logic [DATA_WIDTH-1:0]            RSP_DATA,
    output logic [1:0]                       RSP_RESP,
    output logic [ADDR_WIDTH-1:0]            M_AWADDR,
    output logic                             M_AWVALID,
    input  logic                             M_AWREADY,
    output logic [DATA_WIDTH-1:0]            M_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_WSTRB,
    output logic                             M_WVALID,
    input  logic                             M_WREADY,
    input  logic [1:0]                       M_BRESP,
    input  logic                             M_BVALID,
    output logic                             M_BREADY,
    output logic [ADDR_WIDTH-1:0]            M_ARADDR,
    output logic                             M_ARVALID,
    input  logic                             M_ARREADY,
    input  logic [DATA_WIDTH-1:0]            M_RDATA,
    input  logic [1:0]                       M_RRESP,
    input  logic                             M_RVALID,
    output logic                             M_RREADY,
    output logic                             BUSY
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;

    state_t            state, state_nx;
    logic [GW-1:0]     last, pick, idx_g;
    logic              found;
    int                idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]     wstrb;
    logic              aw_done, w_done, aw_hs, w_hs, tmo;
    logic [CW-1:0]     cnt;

    assign M_AWADDR = addr;
    assign M_ARADDR = addr;
    assign M_WDATA  = wdata;
    assign M_WSTRB  = wstrb;
    assign aw_hs    = M_AWVALID && M_AWREADY;
    assign w_hs     = M_WVALID && M_WREADY;
    assign tmo      = cnt >= CW'(TIMEOUT - 1);

    // last doubles as the owner of the transaction in flight
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = 0;
        idx_g = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = int'(last) + i;
            idx   = idx >= NUM_REQ ? idx - NUM_REQ : idx;
            idx_g = GW'(idx);
            if (!found && REQ_VALID[idx_g]) begin
                found = 1'b1;
                pick  = idx_g;
            end
        end
    end

    always_comb begin
        REQ_READY = '0;
        RSP_VALID = '0;
        if (state == IDLE && found) REQ_READY[pick] = 1'b1;
        if (state == DONE) RSP_VALID[last] = 1'b1;
        M_AWVALID = state == WR_ADDR && !aw_done;
        M_WVALID  = state == WR_ADDR && !w_done;
        M_BREADY  = state == WR_RESP;
        M_ARVALID = state == RD_ADDR;
        M_RREADY  = state == RD_DATA;
        BUSY      = state != IDLE;
    end

    // a partial handshake in the expiry cycle defers the abort by a cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = REQ_WRITE[pick] ? WR_ADDR : RD_ADDR;
            WR_ADDR: state_nx = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP :
                                (tmo && !aw_hs && !w_hs) ? DONE : WR_ADDR;
            WR_RESP: state_nx = M_BVALID ? DONE : WR_RESP;
            RD_ADDR: state_nx = M_ARREADY ? RD_DATA : tmo ? DONE : RD_ADDR;
            RD_DATA: state_nx = M_RVALID ? DONE : RD_DATA;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            last     <= '0;
            addr     <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            cnt      <= '0;
            RSP_DATA <= '0;
            RSP_RESP <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? '0 : cnt + 1'b1;
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
            if (state == IDLE && found) begin
                last    <= pick;
                addr    <= REQ_ADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
                wdata   <= REQ_WDATA[pick*DATA_WIDTH +: DATA_WIDTH];
                wstrb   <= REQ_WSTRB[pick*SW +: SW];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == WR_RESP && M_BVALID) RSP_RESP <= M_BRESP;
            if (state == RD_DATA && M_RVALID) begin
                RSP_DATA <= M_RDATA;
                RSP_RESP <= M_RRESP;
            end
            if ((state == WR_ADDR || state == RD_ADDR) && state_nx == DONE) RSP_RESP <= 2'b11;
        end
    end
endmodule
